cache_data_array_fill: RTL and testbench
========================================

Name: cache_data_array_fill

Overview:
- Parametrised successor to the 64-block by 8-word, 16-bit cache data array.
- Block and word selection use binary indices instead of one-hot enables.
- Read data is registered and flagged with a valid pulse.
- An internal line-fill sequencer writes a whole block from memory, one word per beat, and signals completion. The array sits between the cache controller (CPU access port) and the memory interface (fill port).

Parameters:
- DATA_W, 16, bits per word.
- WORDS, 8, words per block; power of two, 2 or more.
- BLOCKS, 64, number of blocks; power of two, 2 or more.
- Local parameters: WRD_W = clog2(WORDS); BLK_W = clog2(BLOCKS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- acc_en  input  1  CPU access request this cycle.
- acc_we  input  1  1 = write, 0 = read.
- acc_blk  input  BLK_W  block index.
- acc_word  input  WRD_W  word index within the block.
- acc_wdata  input  DATA_W  write data.
- acc_rdata  output  DATA_W  registered read data.
- acc_rvalid  output  1  one-cycle pulse; acc_rdata is valid.
- busy  output  1  CPU accesses are ignored this cycle.
- fill_start  input  1  begin a line fill.
- fill_blk  input  BLK_W  block to fill, sampled with fill_start.
- fill_valid  input  1  fill_data beat present.
- fill_data  input  DATA_W  fill word.
- fill_done  output  1  one-cycle pulse after the last fill word is written.

Behaviour:
- Reset (async, immediate on rst=1):
  - all storage words = 0;
  - acc_rdata = 0, acc_rvalid = 0, fill_done = 0;
  - FSM = IDLE, word counter = 0.
  - Reset mid-fill aborts the fill: no fill_done, block contents are zero after reset.
- busy = (state != IDLE) | fill_start. This is combinational, so fill_start wins over a same-cycle CPU access.
- CPU access accepted when acc_en & !busy.
  - Write: mem[acc_blk][acc_word] <= acc_wdata at the edge. No rvalid.
  - Read: acc_rdata <= mem[acc_blk][acc_word]; acc_rvalid = 1 the next cycle, for 1 cycle. Latency is 1.
  - Read immediately after a write to the same address returns the new data.
- acc_rdata holds its last read value when there is no read. acc_rvalid is 0 on rejected or write accesses.
- FSM states:
  - IDLE: on fill_start, latch fill_blk, counter = 0, go to FILL.
  - FILL: each cycle with fill_valid=1, write mem[latched_blk][counter] <= fill_data and increment counter. On the beat where counter == WORDS-1, go to DONE; the counter wraps to 0. Cycles with fill_valid=0 stall with no write.
  - DONE: fill_done = 1 for exactly this cycle, busy = 1, then go to IDLE.
- Ignored inputs:
  - fill_start outside IDLE.
  - fill_valid in IDLE or DONE.
- Back-to-back fills: fill_start in the cycle after DONE is legal. Minimum fill time is WORDS + 1 cycles from start to fill_done.
- Index ranges: all indices are full-range (power-of-two sizes), so no out-of-range handling is needed.

Decomposition:
- Shared package (cache_pkg):
  - fill-state enum {IDLE, FILL, DONE}, 2 bits;
  - default constants DATA_W=16, WORDS=8, BLOCKS=64;
  - clog2 helper.
- Sub-module cache_fill_ctrl holds the FSM, word counter, latched block index, fill write-enable and address generation, and fill_done/busy generation.
- Top level holds the storage array, CPU write/read mux and registered read path.

Test Plan:
- Reset, then read blk 5 word 3 -> acc_rvalid pulse next cycle, acc_rdata = 0x0000.
- Write 0xBEEF to blk 12 word 7, read it the next cycle -> acc_rdata = 0xBEEF one cycle later; blk 12 word 6 still reads 0x0000.
- Fill blk 63 with beats 0x1000..0x1007, with fill_valid dropped for 2 cycles mid-fill:
  - fill_done pulses exactly once, 1 cycle after the 8th beat;
  - busy is high from fill_start until the end of DONE;
  - reads of words 0..7 return 0x1000..0x1007.
- fill_start and an acc write to blk 0 in the same cycle -> write dropped, blk 0 word 0 reads 0; a fill_start pulsed during FILL is ignored and the fill target is unchanged.
- Async rst asserted after 4 fill beats, between clock edges:
  - outputs go to 0 immediately;
  - no fill_done is ever seen;
  - all words of the block read 0;
  - a new full fill after reset completes normally.
- Parameter sweep DATA_W=32, WORDS=4, BLOCKS=16: fill plus readback of blk 15 with 0xDEAD0000..0xDEAD0003 -> correct data, fill_done after the 4th beat.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and defaults for the line-fill cache data array.
// Holds the fill sequencer state encoding and a width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORDS  = 8;
  localparam int DEF_BLOCKS = 64;

  // Bits needed to index 'value' entries; evaluated at elaboration time.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// Line-fill sequencer: accepts one fill word per valid beat into a latched
// block, pulses fill_done for one cycle afterwards and blocks CPU accesses.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter  int WORDS  = DEF_WORDS,
  parameter  int BLOCKS = DEF_BLOCKS,
  localparam int WRD_W  = clog2(WORDS),
  localparam int BLK_W  = clog2(BLOCKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_start,
  input  logic [BLK_W-1:0] fill_blk,
  input  logic             fill_valid,
  output logic             wr_en,
  output logic [BLK_W-1:0] wr_blk,
  output logic [WRD_W-1:0] wr_word,
  output logic             fill_done,
  output logic             busy
);

  fill_state_t      state;
  fill_state_t      state_nxt;
  logic [WRD_W-1:0] cnt;
  logic [WRD_W-1:0] cnt_nxt;
  logic [BLK_W-1:0] blk;
  logic             load_blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Target block only matters while FILL is active, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_blk) begin
      blk <= fill_blk;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_blk  = 1'b0;
    wr_en     = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
          load_blk  = 1'b1;
        end
      end
      FILL: begin
        if (fill_valid) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == WRD_W'(WORDS - 1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // fill_start is folded in so a same-cycle CPU access loses to the fill.
  assign busy    = (state != IDLE) | fill_start;
  assign wr_blk  = blk;
  assign wr_word = cnt;

endmodule

// File: rtl/cache_data_array_fill.sv
// Cache data array with a single CPU access port (registered read, 1-cycle
// latency) and an internal line-fill port driven by cache_fill_ctrl.
module cache_data_array_fill
  import cache_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int WORDS  = DEF_WORDS,
  parameter  int BLOCKS = DEF_BLOCKS,
  localparam int WRD_W  = clog2(WORDS),
  localparam int BLK_W  = clog2(BLOCKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en,
  input  logic              acc_we,
  input  logic [BLK_W-1:0]  acc_blk,
  input  logic [WRD_W-1:0]  acc_word,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              busy,
  input  logic              fill_start,
  input  logic [BLK_W-1:0]  fill_blk,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_done
);

  localparam int ADDR_W = BLK_W + WRD_W;
  localparam int DEPTH  = BLOCKS * WORDS;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fill_we;
  logic [BLK_W-1:0]  fill_wr_blk;
  logic [WRD_W-1:0]  fill_wr_word;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  cache_fill_ctrl #(
    .WORDS  (WORDS),
    .BLOCKS (BLOCKS)
  ) u_fill_ctrl (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_blk   (fill_blk),
    .fill_valid (fill_valid),
    .wr_en      (fill_we),
    .wr_blk     (fill_wr_blk),
    .wr_word    (fill_wr_word),
    .fill_done  (fill_done),
    .busy       (busy)
  );

  assign cpu_rd  = acc_en & ~busy & ~acc_we;
  assign cpu_wr  = acc_en & ~busy & acc_we;
  assign rd_addr = {acc_blk, acc_word};

  // Fill and CPU writes are mutually exclusive: fill writes only while busy.
  always_comb begin
    mem_we  = 1'b0;
    wr_addr = {acc_blk, acc_word};
    wr_data = acc_wdata;
    if (fill_we) begin
      mem_we  = 1'b1;
      wr_addr = {fill_wr_blk, fill_wr_word};
      wr_data = fill_data;
    end else if (cpu_wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Stage p1: registered read data and its valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= cpu_rd;
      if (cpu_rd) begin
        rdata_p1 <= mem[rd_addr];
      end
    end
  end

  assign acc_rdata  = rdata_p1;
  assign acc_rvalid = vld_p1;

endmodule

// File: tb/tb_cache_data_array_fill.sv
// Randomised self-checking bench for cache_data_array_fill against a
// word-array reference model, plus a narrow-geometry instance for a wide fill.
module tb_cache_data_array_fill;

  localparam int DW = 16;
  localparam int NW = 8;
  localparam int NB = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_en = 1'b0, acc_we = 1'b0;
  logic [5:0]  acc_blk = '0;
  logic [2:0]  acc_word = '0;
  logic [15:0] acc_wdata = '0;
  logic [15:0] acc_rdata;
  logic        acc_rvalid, busy;
  logic        fill_start = 1'b0;
  logic [5:0]  fill_blk = '0;
  logic        fill_valid = 1'b0;
  logic [15:0] fill_data = '0;
  logic        fill_done;

  logic        b_acc_en = 1'b0, b_acc_we = 1'b0;
  logic [3:0]  b_acc_blk = '0;
  logic [1:0]  b_acc_word = '0;
  logic [31:0] b_acc_wdata = '0;
  logic [31:0] b_acc_rdata;
  logic        b_acc_rvalid, b_busy;
  logic        b_fill_start = 1'b0;
  logic [3:0]  b_fill_blk = '0;
  logic        b_fill_valid = 1'b0;
  logic [31:0] b_fill_data = '0;
  logic        b_fill_done;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ref_mem [NB][NW];
  bit          in_fill, in_done;
  int          fill_tgt, beats;
  logic [15:0] exp_rdata;
  bit          exp_rvalid;

  always #5 clk = ~clk;

  cache_data_array_fill u_dut (
    .clk(clk), .rst(rst),
    .acc_en(acc_en), .acc_we(acc_we), .acc_blk(acc_blk), .acc_word(acc_word),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
    .busy(busy), .fill_start(fill_start), .fill_blk(fill_blk),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_done(fill_done)
  );

  cache_data_array_fill #(.DATA_W(32), .WORDS(4), .BLOCKS(16)) u_dut_b (
    .clk(clk), .rst(rst),
    .acc_en(b_acc_en), .acc_we(b_acc_we), .acc_blk(b_acc_blk), .acc_word(b_acc_word),
    .acc_wdata(b_acc_wdata), .acc_rdata(b_acc_rdata), .acc_rvalid(b_acc_rvalid),
    .busy(b_busy), .fill_start(b_fill_start), .fill_blk(b_fill_blk),
    .fill_valid(b_fill_valid), .fill_data(b_fill_data), .fill_done(b_fill_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        ref_mem[b][w] = '0;
    in_fill    = 0;
    in_done    = 0;
    beats      = 0;
    exp_rdata  = '0;
    exp_rvalid = 0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input bit en, input bit we, input int blk, input int word,
                       input logic [15:0] wd, input bit fs, input int fb,
                       input bit fv, input logic [15:0] fd);
    bit eb, acc;
    @(negedge clk);
    acc_en = en; acc_we = we; acc_blk = blk[5:0]; acc_word = word[2:0];
    acc_wdata = wd; fill_start = fs; fill_blk = fb[5:0];
    fill_valid = fv; fill_data = fd;
    #1;
    eb = in_fill || in_done || fs;
    chk("busy", busy, eb);
    chk("fill_done", fill_done, in_done);
    acc = en && !eb;
    exp_rvalid = acc && !we;
    if (acc && !we) exp_rdata = ref_mem[blk][word];
    if (acc && we) ref_mem[blk][word] = wd;
    if (in_done) begin
      in_done = 0;
    end else if (in_fill) begin
      if (fv) begin
        ref_mem[fill_tgt][beats] = fd;
        beats++;
        if (beats == NW) begin
          in_fill = 0;
          in_done = 1;
        end
      end
    end else if (fs) begin
      in_fill  = 1;
      fill_tgt = fb;
      beats    = 0;
    end
    @(posedge clk);
    #1;
    chk("rvalid", acc_rvalid, exp_rvalid);
    chk("rdata", acc_rdata, exp_rdata);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask
  task automatic wr(input int b, input int w, input logic [15:0] d);
    cycle(1, 1, b, w, d, 0, 0, 0, '0);
  endtask
  task automatic rd(input int b, input int w);
    cycle(1, 0, b, w, '0, 0, 0, 0, '0);
  endtask
  task automatic beat(input logic [15:0] d);
    cycle(0, 0, 0, 0, '0, 0, 0, 1, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    chk("reset_rdata", acc_rdata, 16'h0);
    chk("reset_rvalid", acc_rvalid, 1'b0);
    chk("reset_done", fill_done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    rd(5, 3);
    wr(12, 7, 16'hBEEF);
    rd(12, 7);
    rd(12, 6);
    idle();

    // Fill blk 63 with a two-cycle stall after the fourth beat.
    cycle(0, 0, 0, 0, '0, 1, 63, 0, '0);
    for (int i = 0; i < NW; i++) begin
      beat(16'h1000 + 16'(i));
      if (i == 3) begin
        idle();
        idle();
      end
    end
    idle();
    idle();
    for (int i = 0; i < NW; i++) rd(63, i);

    // Same-cycle fill_start beats a CPU write; a fill_start during FILL is ignored.
    cycle(1, 1, 0, 0, 16'h1234, 1, 10, 0, '0);
    for (int i = 0; i < NW; i++) begin
      if (i == 2) cycle(0, 0, 0, 0, '0, 1, 20, 0, '0);
      beat(16'hA000 + 16'(i));
    end
    idle();
    rd(0, 0);
    for (int i = 0; i < NW; i++) rd(10, i);
    rd(20, 0);
    rd(20, 7);

    // Asynchronous reset mid-fill, asserted between clock edges.
    rd(63, 1);
    cycle(0, 0, 0, 0, '0, 1, 30, 0, '0);
    for (int i = 0; i < 4; i++) beat(16'h5500 + 16'(i));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rdata", acc_rdata, 16'h0);
    chk("arst_rvalid", acc_rvalid, 1'b0);
    chk("arst_done", fill_done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NW; i++) rd(30, i);
    rd(63, 1);
    cycle(0, 0, 0, 0, '0, 1, 30, 0, '0);
    for (int i = 0; i < NW; i++) beat(16'h6600 + 16'(i));
    idle();
    for (int i = 0; i < NW; i++) rd(30, i);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(1, 0) == 1), ($urandom_range(1, 0) == 1),
            $urandom_range(NB - 1, 0), $urandom_range(NW - 1, 0), 16'($urandom),
            ($urandom_range(39, 0) == 0), $urandom_range(NB - 1, 0),
            ($urandom_range(9, 0) < 7), 16'($urandom));
    end
    for (int n = 0; n < 20 && (in_fill || in_done); n++) beat(16'($urandom));
    chk("drain_idle", {in_fill, in_done}, 2'b00);
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        rd(b, w);

    // Narrow-geometry instance: 32-bit words, 4 words per block, 16 blocks.
    @(negedge clk);
    acc_en = 1'b0; fill_start = 1'b0; fill_valid = 1'b0;
    b_fill_start = 1'b1;
    b_fill_blk   = 4'd15;
    #1;
    chk("b_busy_start", b_busy, 1'b1);
    chk("b_done_start", b_fill_done, 1'b0);
    @(negedge clk);
    b_fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_fill_valid = 1'b1;
      b_fill_data  = 32'hDEAD0000 + 32'(i);
      #1;
      chk("b_done_beat", b_fill_done, 1'b0);
      chk("b_busy_beat", b_busy, 1'b1);
      @(negedge clk);
    end
    b_fill_valid = 1'b0;
    #1;
    chk("b_done_pulse", b_fill_done, 1'b1);
    chk("b_busy_done", b_busy, 1'b1);
    @(negedge clk);
    #1;
    chk("b_done_clear", b_fill_done, 1'b0);
    chk("b_busy_clear", b_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_acc_en   = 1'b1;
      b_acc_we   = 1'b0;
      b_acc_blk  = 4'd15;
      b_acc_word = 2'(i);
      @(posedge clk);
      #1;
      chk("b_rvalid", b_acc_rvalid, 1'b1);
      chk("b_rdata", b_acc_rdata, 32'hDEAD0000 + 32'(i));
    end
    @(negedge clk);
    b_acc_en = 1'b0;
    @(posedge clk);
    #1;
    chk("b_rvalid_off", b_acc_rvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
